// File: rtl/matched_filter_pkg.sv
// Shared types and default widths for the matched-filter datapath.
//   ScoreWidth / IndexWidth : default score and sample-index widths
//   score_t                 : score at the default width
//   state_e                 : peak-detector FSM states
package matched_filter_pkg;

  localparam int unsigned ScoreWidth = 16;
  localparam int unsigned IndexWidth = 16;

  typedef logic [ScoreWidth-1:0] score_t;

  typedef enum logic [1:0] {
    StSearch  = 2'd0,
    StAbove   = 2'd1,
    StReport  = 2'd2,
    StHoldoff = 2'd3
  } state_e;

endpackage

// File: rtl/match_peak_detector_if.sv
// Score stream in / detection event out for match_peak_detector.
//   axiiv, axiid, threshold : score valid, score, entry threshold (producer -> detector)
//   axiov, axiod            : one-cycle detection pulse and peak score (detector -> consumer)
//   peak_index              : sample index of the peak
//   timeout_flag            : report was forced by the run-length limit
// modport master: the score producer / event consumer; modport slave: the detector.
interface match_peak_detector_if
  import matched_filter_pkg::*;
#(
  parameter int unsigned MATCH_SCORE_WIDTH = ScoreWidth,
  parameter int unsigned INDEX_WIDTH       = IndexWidth
);

  logic                         axiiv;
  logic [MATCH_SCORE_WIDTH-1:0] axiid;
  logic [MATCH_SCORE_WIDTH-1:0] threshold;
  logic                         axiov;
  logic [MATCH_SCORE_WIDTH-1:0] axiod;
  logic [INDEX_WIDTH-1:0]       peak_index;
  logic                         timeout_flag;

  modport master (
    output axiiv, axiid, threshold,
    input  axiov, axiod, peak_index, timeout_flag
  );

  modport slave (
    input  axiiv, axiid, threshold,
    output axiov, axiod, peak_index, timeout_flag
  );

endinterface

// File: rtl/match_peak_detector.sv
// Threshold-with-hysteresis peak detector on the matched-filter score stream.
// Tracks the maximum score of each above-threshold run and reports it once when
// the run ends (score drops below threshold-HYSTERESIS, or MAX_RUN samples),
// then ignores HOLDOFF_SAMPLES valid samples.
//   clk, rst : clock, synchronous active-high reset
//   mpd      : slave side of match_peak_detector_if (score in, event out)
module match_peak_detector
  import matched_filter_pkg::*;
#(
  parameter int unsigned MATCH_SCORE_WIDTH = ScoreWidth,
  parameter int unsigned INDEX_WIDTH       = IndexWidth,
  parameter int unsigned HYSTERESIS        = 16,
  parameter int unsigned HOLDOFF_SAMPLES   = 100,
  parameter int unsigned MAX_RUN           = 255
) (
  input logic                  clk,
  input logic                  rst,
  match_peak_detector_if.slave mpd
);

  localparam int unsigned RunW  = $clog2(MAX_RUN + 1);
  localparam int unsigned HoldW = (HOLDOFF_SAMPLES > 0) ? $clog2(HOLDOFF_SAMPLES + 1) : 1;

  localparam logic [RunW-1:0]              MaxRunC = RunW'(MAX_RUN);
  localparam logic [HoldW-1:0]             HoldC   = HoldW'(HOLDOFF_SAMPLES);
  localparam logic [MATCH_SCORE_WIDTH-1:0] HystC   = MATCH_SCORE_WIDTH'(HYSTERESIS);

  state_e                       state_q, state_d;
  logic [INDEX_WIDTH-1:0]       sample_idx_q, sample_idx_d;
  logic [MATCH_SCORE_WIDTH-1:0] peak_q, peak_d;
  logic [INDEX_WIDTH-1:0]       peak_idx_q, peak_idx_d;
  logic [RunW-1:0]              run_cnt_q, run_cnt_d, run_cnt_inc;
  logic [HoldW-1:0]             hold_cnt_q, hold_cnt_d, hold_cnt_inc;
  logic                         timeout_d;
  logic [MATCH_SCORE_WIDTH-1:0] exit_level;

  logic                         axiov_q;
  logic [MATCH_SCORE_WIDTH-1:0] axiod_q;
  logic [INDEX_WIDTH-1:0]       peak_index_q;
  logic                         timeout_flag_q;

  always_comb begin
    exit_level   = (mpd.threshold > HystC) ? mpd.threshold - HystC : '0;
    run_cnt_inc  = run_cnt_q + 1'b1;
    hold_cnt_inc = hold_cnt_q + 1'b1;

    state_d      = state_q;
    peak_d       = peak_q;
    peak_idx_d   = peak_idx_q;
    run_cnt_d    = run_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    timeout_d    = 1'b0;
    // The index advances on every accepted sample, whatever the state.
    sample_idx_d = mpd.axiiv ? sample_idx_q + 1'b1 : sample_idx_q;

    unique case (state_q)
      StSearch: begin
        if (mpd.axiiv && (mpd.axiid >= mpd.threshold)) begin
          peak_d     = mpd.axiid;
          peak_idx_d = sample_idx_q;
          run_cnt_d  = RunW'(1);
          state_d    = StAbove;
        end
      end
      StAbove: begin
        if (mpd.axiiv) begin
          if (mpd.axiid < exit_level) begin
            // The exiting sample is not a peak candidate.
            state_d = StReport;
          end else begin
            // Strict compare: ties keep the earliest index.
            if (mpd.axiid > peak_q) begin
              peak_d     = mpd.axiid;
              peak_idx_d = sample_idx_q;
            end
            run_cnt_d = run_cnt_inc;
            if (run_cnt_inc == MaxRunC) begin
              state_d   = StReport;
              timeout_d = 1'b1;
            end
          end
        end
      end
      StReport: begin
        // A sample accepted during the report cycle is the first holdoff sample.
        hold_cnt_d = mpd.axiiv ? HoldW'(1) : '0;
        if (HOLDOFF_SAMPLES == 0) begin
          state_d = StSearch;
        end else if (hold_cnt_d == HoldC) begin
          state_d = StSearch;
        end else begin
          state_d = StHoldoff;
        end
      end
      StHoldoff: begin
        if (mpd.axiiv) begin
          hold_cnt_d = hold_cnt_inc;
          if (hold_cnt_inc == HoldC) begin
            state_d = StSearch;
          end
        end
      end
      default: state_d = StSearch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StSearch;
      sample_idx_q   <= '0;
      peak_q         <= '0;
      peak_idx_q     <= '0;
      run_cnt_q      <= '0;
      hold_cnt_q     <= '0;
      axiov_q        <= 1'b0;
      axiod_q        <= '0;
      peak_index_q   <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_idx_q <= sample_idx_d;
      peak_q       <= peak_d;
      peak_idx_q   <= peak_idx_d;
      run_cnt_q    <= run_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      // REPORT is only entered from ABOVE and lasts one cycle, so the pulse
      // can never be two cycles long.
      axiov_q      <= (state_d == StReport);
      if (state_d == StReport) begin
        axiod_q        <= peak_d;
        peak_index_q   <= peak_idx_d;
        timeout_flag_q <= timeout_d;
      end
    end
  end

  assign mpd.axiov        = axiov_q;
  assign mpd.axiod        = axiod_q;
  assign mpd.peak_index   = peak_index_q;
  assign mpd.timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_match_peak_detector.sv
// Self-checking bench for match_peak_detector. Each scenario records the driven
// trace; a trace-scanning reference model derives the expected events, which are
// compared with the observed outputs, followed by scenario-specific checks.
module tb_match_peak_detector;
  import matched_filter_pkg::*;

  localparam int unsigned SW     = 16;
  localparam int unsigned IW     = 16;
  localparam int          HYST   = 16;
  localparam int          HOLD   = 100;
  localparam int          MAXRUN = 255;

  logic clk = 1'b0;
  logic rst;

  match_peak_detector_if #(.MATCH_SCORE_WIDTH(SW), .INDEX_WIDTH(IW)) mpd ();

  match_peak_detector #(
    .MATCH_SCORE_WIDTH(SW),
    .INDEX_WIDTH      (IW),
    .HYSTERESIS       (HYST),
    .HOLDOFF_SAMPLES  (HOLD),
    .MAX_RUN          (MAXRUN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mpd(mpd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Driven trace of the current segment (one entry per cycle).
  logic   in_v[$];
  score_t in_d[$];
  score_t in_t[$];
  // Observed outputs for the same cycles.
  logic            ob_v[$];
  score_t          ob_d[$];
  logic [IW-1:0]   ob_i[$];
  logic            ob_t[$];
  // Observed events of the last finished segment.
  int              ev_cyc[$];
  score_t          ev_d[$];
  logic [IW-1:0]   ev_i[$];
  logic            ev_t[$];

  logic          prev_v;
  score_t        prev_d;
  logic [IW-1:0] prev_i;
  logic          prev_t;
  score_t        last_thr;

  score_t seq1[6] = '{16'd0, 16'd0, 16'd1200, 16'd1500, 16'd1400, 16'd900};

  task automatic start_segment();
    in_v.delete(); in_d.delete(); in_t.delete();
    ob_v.delete(); ob_d.delete(); ob_i.delete(); ob_t.delete();
    prev_v = mpd.axiov;
    prev_d = mpd.axiod;
    prev_i = mpd.peak_index;
    prev_t = mpd.timeout_flag;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    mpd.axiiv = 1'b0;
    mpd.axiid = '0;
    mpd.threshold = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    start_segment();
  endtask

  // One cycle: observe current outputs, drive inputs sampled at the next edge.
  task automatic step(input logic v, input score_t d, input score_t t);
    mpd.axiiv = v;
    mpd.axiid = d;
    mpd.threshold = t;
    last_thr = t;
    if (mpd.axiov === 1'b1) begin
      checks++;
      if (prev_v === 1'b1) begin
        errors++;
        $display("FAIL pulse_width: axiov high two cycles at cycle %0d", in_v.size());
      end
    end else begin
      checks++;
      if (mpd.axiod !== prev_d || mpd.peak_index !== prev_i || mpd.timeout_flag !== prev_t) begin
        errors++;
        $display("FAIL hold: outputs changed without axiov at cycle %0d (d %0d->%0d i %0d->%0d)",
                 in_v.size(), prev_d, mpd.axiod, prev_i, mpd.peak_index);
      end
    end
    prev_v = mpd.axiov;
    prev_d = mpd.axiod;
    prev_i = mpd.peak_index;
    prev_t = mpd.timeout_flag;
    ob_v.push_back(mpd.axiov);
    ob_d.push_back(mpd.axiod);
    ob_i.push_back(mpd.peak_index);
    ob_t.push_back(mpd.timeout_flag);
    in_v.push_back(v);
    in_d.push_back(d);
    in_t.push_back(t);
    @(posedge clk);
    #1;
  endtask

  // Drain, scan the recorded trace for expected events, and compare.
  task automatic finish_segment(input string name);
    int            n, c, cnt, len, nexp, nobs;
    logic [IW-1:0] sidx, pidx;
    score_t        peak, ex;
    logic          tmo, done;
    int            e_cyc[$];
    score_t        e_d[$];
    logic [IW-1:0] e_i[$];
    logic          e_t[$];

    step(1'b0, '0, last_thr);
    step(1'b0, '0, last_thr);
    n = in_v.size();
    c = 0;
    sidx = '0;
    while (c < n) begin
      if (!in_v[c]) begin
        c++;
      end else if (in_d[c] < in_t[c]) begin
        sidx++;
        c++;
      end else begin
        peak = in_d[c]; pidx = sidx; len = 1; tmo = 1'b0; done = 1'b0;
        sidx++;
        c++;
        while (c < n && !done) begin
          if (in_v[c]) begin
            ex = (int'(in_t[c]) > HYST) ? score_t'(int'(in_t[c]) - HYST) : '0;
            if (in_d[c] < ex) begin
              done = 1'b1;
            end else begin
              if (in_d[c] > peak) begin
                peak = in_d[c];
                pidx = sidx;
              end
              len++;
              if (len == MAXRUN) begin
                done = 1'b1;
                tmo = 1'b1;
              end
            end
            sidx++;
          end
          c++;
        end
        if (!done) break;
        // c is now the report cycle.
        e_cyc.push_back(c); e_d.push_back(peak); e_i.push_back(pidx); e_t.push_back(tmo);
        cnt = 0;
        if (c < n && in_v[c]) begin
          cnt = 1;
          sidx++;
        end
        c++;
        while (c < n && cnt < HOLD) begin
          if (in_v[c]) begin
            cnt++;
            sidx++;
          end
          c++;
        end
      end
    end

    nexp = 0;
    foreach (e_cyc[k]) begin
      if (e_cyc[k] < n) begin
        nexp++;
        checks++;
        if (ob_v[e_cyc[k]] !== 1'b1) begin
          errors++;
          $display("FAIL %s axiov: cycle %0d got %b want 1", name, e_cyc[k], ob_v[e_cyc[k]]);
        end
        checks++;
        if (ob_d[e_cyc[k]] !== e_d[k]) begin
          errors++;
          $display("FAIL %s axiod: cycle %0d got %0d want %0d", name, e_cyc[k],
                   ob_d[e_cyc[k]], e_d[k]);
        end
        checks++;
        if (ob_i[e_cyc[k]] !== e_i[k]) begin
          errors++;
          $display("FAIL %s peak_index: cycle %0d got %0d want %0d", name, e_cyc[k],
                   ob_i[e_cyc[k]], e_i[k]);
        end
        checks++;
        if (ob_t[e_cyc[k]] !== e_t[k]) begin
          errors++;
          $display("FAIL %s timeout_flag: cycle %0d got %b want %b", name, e_cyc[k],
                   ob_t[e_cyc[k]], e_t[k]);
        end
      end
    end

    ev_cyc.delete(); ev_d.delete(); ev_i.delete(); ev_t.delete();
    nobs = 0;
    foreach (ob_v[k]) begin
      if (ob_v[k] === 1'b1) begin
        nobs++;
        ev_cyc.push_back(k); ev_d.push_back(ob_d[k]); ev_i.push_back(ob_i[k]);
        ev_t.push_back(ob_t[k]);
      end
    end
    checks++;
    if (nobs != nexp) begin
      errors++;
      $display("FAIL %s event_count: got %0d want %0d", name, nobs, nexp);
    end
  endtask

  // Fixed expectation for a single-event scenario.
  task automatic expect_one(input string name, input int cyc, input score_t d,
                            input logic [IW-1:0] idx, input logic tmo);
    checks++;
    if (ev_cyc.size() != 1) begin
      errors++;
      $display("FAIL %s single_event: got %0d events want 1", name, ev_cyc.size());
    end else begin
      checks++;
      if (ev_cyc[0] != cyc || ev_d[0] !== d || ev_i[0] !== idx || ev_t[0] !== tmo) begin
        errors++;
        $display("FAIL %s event: got cyc %0d d %0d idx %0d to %b want cyc %0d d %0d idx %0d to %b",
                 name, ev_cyc[0], ev_d[0], ev_i[0], ev_t[0], cyc, d, idx, tmo);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (mpd.axiov !== 1'b0 || mpd.axiod !== '0 || mpd.peak_index !== '0 ||
        mpd.timeout_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v %b d %0d i %0d to %b want all 0", mpd.axiov,
               mpd.axiod, mpd.peak_index, mpd.timeout_flag);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    foreach (seq1[k]) step(1'b1, seq1[k], 16'd1000);
    finish_segment("basic");
    expect_one("basic", 6, 16'd1500, 16'd3, 1'b0);
  endtask

  task automatic test_hysteresis();
    score_t s[4] = '{16'd1000, 16'd990, 16'd1100, 16'd970};
    apply_reset();
    foreach (s[k]) step(1'b1, s[k], 16'd1000);
    finish_segment("hysteresis");
    expect_one("hysteresis", 4, 16'd1100, 16'd2, 1'b0);
  endtask

  task automatic test_holdoff();
    apply_reset();
    step(1'b1, 16'd1200, 16'd1000);
    step(1'b1, 16'd1500, 16'd1000);
    step(1'b1, 16'd900, 16'd1000);
    step(1'b0, 16'd0, 16'd1000);  // report cycle, no sample
    for (int k = 1; k <= HOLD; k++) step(1'b1, (k == HOLD) ? 16'd2000 : 16'd0, 16'd1000);
    step(1'b1, 16'd2000, 16'd1000);  // 101st valid sample after the event
    step(1'b1, 16'd0, 16'd1000);
    finish_segment("holdoff");
    checks++;
    if (ev_cyc.size() != 2) begin
      errors++;
      $display("FAIL holdoff events: got %0d want 2", ev_cyc.size());
    end else begin
      checks++;
      if (ev_cyc[1] != 106 || ev_d[1] !== 16'd2000 || ev_i[1] !== 16'd103) begin
        errors++;
        $display("FAIL holdoff retrigger: got cyc %0d d %0d idx %0d want cyc 106 d 2000 idx 103",
                 ev_cyc[1], ev_d[1], ev_i[1]);
      end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    repeat (300) step(1'b1, 16'd1200, 16'd1000);
    finish_segment("timeout");
    expect_one("timeout", 255, 16'd1200, 16'd0, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    for (int k = 0; k < 4; k++) step(1'b1, seq1[k], 16'd1000);
    finish_segment("mid_run_pre");
    checks++;
    if (ev_cyc.size() != 0) begin
      errors++;
      $display("FAIL mid_run no_event: got %0d events want 0", ev_cyc.size());
    end
    apply_reset();
    checks++;
    if (mpd.axiov !== 1'b0) begin
      errors++;
      $display("FAIL mid_run reset_axiov: got %b want 0", mpd.axiov);
    end
    foreach (seq1[k]) step(1'b1, seq1[k], 16'd1000);
    finish_segment("mid_run_post");
    expect_one("mid_run_post", 6, 16'd1500, 16'd3, 1'b0);
  endtask

  task automatic test_bubbles();
    int end_cyc;
    apply_reset();
    end_cyc = 0;
    foreach (seq1[k]) begin
      end_cyc = in_v.size();
      step(1'b1, seq1[k], 16'd1000);
      repeat ($urandom_range(1, 3)) step(1'b0, score_t'($urandom), 16'd1000);
    end
    finish_segment("bubbles");
    expect_one("bubbles", end_cyc + 1, 16'd1500, 16'd3, 1'b0);
  endtask

  task automatic test_low_threshold();
    apply_reset();
    step(1'b1, 16'd1200, 16'd10);
    repeat (299) step(1'b1, score_t'($urandom_range(0, 65535)), 16'd10);
    finish_segment("low_threshold");
    checks++;
    if (ev_cyc.size() != 1) begin
      errors++;
      $display("FAIL low_threshold events: got %0d want 1", ev_cyc.size());
    end else begin
      checks++;
      if (ev_t[0] !== 1'b1 || ev_cyc[0] != 255) begin
        errors++;
        $display("FAIL low_threshold timeout: got to %b cyc %0d want to 1 cyc 255",
                 ev_t[0], ev_cyc[0]);
      end
    end
  endtask

  task automatic test_random();
    score_t thr;
    apply_reset();
    thr = 16'd1000;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 150) == 0) thr = score_t'($urandom_range(0, 1500));
      step($urandom_range(0, 3) != 0, score_t'($urandom_range(0, 2000)), thr);
    end
    finish_segment("random");
  endtask

  initial begin
    rst = 1'b1;
    last_thr = '0;
    test_reset();
    test_basic();
    test_hysteresis();
    test_holdoff();
    test_timeout();
    test_reset_mid_run();
    test_bubbles();
    test_low_threshold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/match_peak_detector.md
Name: match_peak_detector

Overview:
Downstream stage of the matched filter. Consumes the stream of match scores, applies a threshold with hysteresis, and tracks the maximum score within each above-threshold run. When a run ends, it emits one detection event carrying the peak score and the sample index of that peak. It then holds off re-triggering for a programmable number of samples so that one correlation peak produces exactly one event.

Parameters:
MATCH_SCORE_WIDTH, 16, width of incoming scores and of the reported peak.
INDEX_WIDTH, 16, width of the valid-sample counter; the counter wraps.
HYSTERESIS, 16, exit level is threshold minus HYSTERESIS, saturated at 0.
HOLDOFF_SAMPLES, 100, valid samples ignored after a report; 0 disables holdoff.
MAX_RUN, 255, maximum run length in valid samples before a forced report.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
axiiv  in  1  score valid.
axiid  in  MATCH_SCORE_WIDTH  match score, unsigned.
threshold  in  MATCH_SCORE_WIDTH  entry level, unsigned; sampled every valid cycle.
axiov  out  1  detection event, one-cycle pulse.
axiod  out  MATCH_SCORE_WIDTH  peak score; valid while axiov=1.
peak_index  out  INDEX_WIDTH  sample index of the peak; valid while axiov=1.
timeout_flag  out  1  set with axiov when the report was forced by MAX_RUN.

Behaviour:
- Reset: axiov=0, axiod=0, peak_index=0, timeout_flag=0, state=SEARCH, sample_idx=0, peak registers and run/holdoff counters cleared. A reset mid-run discards the run and produces no event.
- Input handling:
  - Only cycles with axiiv=1 advance anything. With axiiv=0, state and all counters hold.
  - There is no backpressure; every valid sample is accepted.
- sample_idx:
  - The first valid sample after reset has index 0.
  - It increments after each valid sample and wraps from 2^INDEX_WIDTH-1 to 0.
- exit_level = (threshold > HYSTERESIS) ? threshold-HYSTERESIS : 0. All comparisons are unsigned.
- SEARCH:
  - On a valid sample with axiid >= threshold, load peak=axiid, peak_idx=sample_idx, run_cnt=1, and go to ABOVE.
- ABOVE, on each valid sample:
  - If axiid < exit_level, go to REPORT. The exiting sample is not a peak candidate.
  - Else if axiid > peak (strictly greater; ties keep the earliest index), update peak and peak_idx.
  - In the non-exiting case, increment run_cnt. If the incremented run_cnt equals MAX_RUN, go to REPORT with timeout set.
- REPORT:
  - A single cycle regardless of axiiv. The event fires in the cycle after the terminating sample is accepted: axiov=1, axiod=peak, peak_index=peak_idx, timeout_flag as set.
  - A valid sample arriving during REPORT still increments sample_idx but is otherwise ignored.
  - Next state: HOLDOFF if HOLDOFF_SAMPLES>0, else SEARCH.
- HOLDOFF:
  - Count valid samples. After HOLDOFF_SAMPLES of them, return to SEARCH.
  - The REPORT-cycle sample counts toward the holdoff.
  - The next sample after the holdoff is eligible to trigger.
- Output timing:
  - axiov is never high for two consecutive cycles.
  - axiod, peak_index and timeout_flag hold their last values while axiov=0.
- Threshold changes take effect at the next valid sample. In ABOVE, a raised threshold can terminate the run early through exit_level.
- threshold <= HYSTERESIS: exit_level=0, so a run ends only by MAX_RUN.

Decomposition:
- Package matched_filter_pkg holds:
  - the state enum (SEARCH, ABOVE, REPORT, HOLDOFF) as a 2-bit typedef;
  - default width constants shared with matched_filter (MATCH_SCORE_WIDTH=16);
  - the score_t typedef.
- No sub-module is needed. The holdoff counter and run counter are inline; together the RTL is roughly 150-200 lines.

Test Plan:
1. Basic event, threshold=1000, scores 0,0,1200,1500,1400,900 → one axiov pulse the cycle after 900 is accepted; axiod=1500, peak_index=3, timeout_flag=0.
2. Hysteresis, threshold=1000, scores 1000,990,1100,970 → 990 keeps the run (>=984); 970 ends it; axiod=1100, peak_index=2.
3. Holdoff → a score of 2000 within 100 valid samples after a report produces no event; the same 2000 presented as the 101st valid sample after the event triggers a new run.
4. Timeout, threshold=1000, constant 1200 for 300 samples starting at idx 0 → one event after the 255th sample; axiod=1200, peak_index=0 (tie keeps first), timeout_flag=1; no second event during holdoff.
5. Reset mid-run: assert rst while in ABOVE → no axiov; the next valid sample gets index 0; the test 1 sequence then reproduces test 1 results exactly.
6. Bubbles: test 1 sequence with axiiv=0 gaps of 1-3 cycles between samples → identical axiod and peak_index. threshold=10 with all scores >=0 → only MAX_RUN ends the run; timeout_flag=1.
